// File: rtl/pixel_readout_pkg.sv
// Shared types and helpers for the pixel readout sequencer.
// Holds the readout FSM state enum and the select-width helper.
package pixel_readout_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    SAMPLE  = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } readout_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster counter for the pixel readout sequencer.
// Ports: clk, reset (async low), clear, advance -> row, col, last.
module raster_counter
  import pixel_readout_pkg::*;
#(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  localparam int RW = clog2_min1(N_ROWS),
  localparam int CW = clog2_min1(N_COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(N_COLS - 1);

  logic row_end;
  logic col_end;

  assign row_end = (row == ROW_MAX);
  assign col_end = (col == COL_MAX);
  assign last    = row_end & col_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_readout.sv
// Frame readout sequencer: walks the pixel array in raster order after
// the ADC finishes and streams codes out over valid/ready.
// Ports: clk, reset (async low), adc_finished, pixel_data -> row_sel,
// col_sel, read_enable, out_data, out_valid, busy, frame_done, overrun;
// out_ready in. Macro PIXEL_READOUT_PARITY_EN adds out_parity.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          adc_finished,
  input  logic [DATA_W-1:0]             pixel_data,
  output logic [clog2_min1(N_ROWS)-1:0] row_sel,
  output logic [clog2_min1(N_COLS)-1:0] col_sel,
  output logic                          read_enable,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
`ifdef PIXEL_READOUT_PARITY_EN
  output logic                          out_parity,
`endif
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun
);

  readout_state_t state_q, state_d;

  logic              adc_prev;
  logic              start;
  logic              clear;
  logic              advance;
  logic              last;
  logic              re_d;
  logic              valid_d;
  logic              done_d;
  logic              ovr_d;
  logic [DATA_W-1:0] data_d;

  // adc_prev resets high so a level already up at release is ignored
  assign start = adc_finished & ~adc_prev;

  raster_counter #(
    .N_ROWS(N_ROWS),
    .N_COLS(N_COLS)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .advance(advance),
    .row    (row_sel),
    .col    (col_sel),
    .last   (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      adc_prev    <= 1'b1;
      read_enable <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      adc_prev    <= adc_finished;
      read_enable <= re_d;
      out_data    <= data_d;
      out_valid   <= valid_d;
      busy        <= (state_d != IDLE);
      frame_done  <= done_d;
      overrun     <= ovr_d;
    end
  end

`ifdef PIXEL_READOUT_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_parity <= 1'b0;
    else        out_parity <= ^data_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    re_d    = read_enable;
    data_d  = out_data;
    valid_d = out_valid;
    done_d  = 1'b0;
    ovr_d   = overrun;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ovr_d   = 1'b0;
          clear   = 1'b1;
          re_d    = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: state_d = SAMPLE;
      SAMPLE: begin
        data_d  = pixel_data;
        valid_d = 1'b1;
        re_d    = 1'b0;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (out_valid & out_ready) begin
          valid_d = 1'b0;
          if (last) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            advance = 1'b1;
            re_d    = 1'b1;
            state_d = SELECT;
          end
        end
      end
      DONE: begin
        clear   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A start edge mid-frame never restarts; it only flags overrun
    if (start && state_q != IDLE) ovr_d = 1'b1;
  end

endmodule

// File: tb/tb_pixel_readout.sv
// Directed testbench for pixel_readout (2x2 array, 8-bit codes).
// Summary line: Result: errors=<n> of <m> checks.
module tb_pixel_readout;

  logic       clk;
  logic       reset;
  logic       adc_finished;
  logic [7:0] pixel_data;
  logic [0:0] row_sel;
  logic [0:0] col_sel;
  logic       read_enable;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_done;
  logic       overrun;
`ifdef PIXEL_READOUT_PARITY_EN
  logic       out_parity;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] pix [4] = '{8'h10, 8'h20, 8'h30, 8'hFF};

  assign pixel_data = read_enable ? pix[{row_sel, col_sel}] : 8'h00;

  pixel_readout #(
    .N_ROWS(2),
    .N_COLS(2),
    .DATA_W(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_finished(adc_finished),
    .pixel_data  (pixel_data),
    .row_sel     (row_sel),
    .col_sel     (col_sel),
    .read_enable (read_enable),
    .out_data    (out_data),
    .out_valid   (out_valid),
`ifdef PIXEL_READOUT_PARITY_EN
    .out_parity  (out_parity),
`endif
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_row"}, 32'(row_sel), 0);
    check({tag, "_col"}, 32'(col_sel), 0);
    check({tag, "_re"}, 32'(read_enable), 0);
    check({tag, "_data"}, 32'(out_data), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_ovr"}, 32'(overrun), 0);
  endtask

  task automatic frame(input string tag, input int stall_pix,
                       input int inj, input int exp_done,
                       input bit exp_ovr);
    int cnt, k, stall, done_at;
    bit seen, hs;
    logic [7:0] held;
    cnt = 0; k = 0; stall = 0; done_at = 0; seen = 0; held = '0;
    out_ready = 1'b1;
    adc_finished = 1'b0;
    step();
    adc_finished = 1'b1;
    step();
    cnt = 1;
    check({tag, "_re_start"}, 32'(read_enable), 1);
    check({tag, "_busy_start"}, 32'(busy), 1);
    check({tag, "_ovr_clr"}, 32'(overrun), 0);
    while (done_at == 0 && cnt < 100) begin
      if (inj > 0 && cnt == inj) adc_finished = 1'b0;
      if (inj > 0 && cnt == inj + 1) adc_finished = 1'b1;
      hs = out_valid & out_ready;
      step();
      cnt++;
      if (hs) begin
        k++;
        seen = 0;
      end
      if (frame_done) begin
        done_at = cnt;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1;
          held = out_data;
          check({tag, "_data"}, 32'(out_data), 32'(pix[k & 3]));
          check({tag, "_row"}, 32'(row_sel), 32'((k >> 1) & 1));
          check({tag, "_col"}, 32'(col_sel), 32'(k & 1));
`ifdef PIXEL_READOUT_PARITY_EN
          check({tag, "_par"}, 32'(out_parity), 32'(^pix[k & 3]));
`endif
          if (k == 0) check({tag, "_lat"}, cnt, 3);
          if (k == stall_pix) begin
            out_ready = 1'b0;
            stall = 5;
          end
        end else begin
          check({tag, "_hold"}, 32'(out_data), 32'(held));
          check({tag, "_hold_col"}, 32'(col_sel), 32'(k & 1));
          stall--;
          if (stall <= 0) out_ready = 1'b1;
        end
      end
    end
    check({tag, "_done_at"}, done_at, exp_done);
    check({tag, "_pixels"}, k, 4);
    check({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    out_ready = 1'b1;
    step();
    check({tag, "_done_pulse"}, 32'(frame_done), 0);
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_row_end"}, 32'(row_sel), 0);
    check({tag, "_col_end"}, 32'(col_sel), 0);
  endtask

  initial begin
    reset = 1'b0;
    adc_finished = 1'b1;
    out_ready = 1'b1;
    step();
    check_zero("in_reset");
    step();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) step();
    check_zero("rel_high");

    frame("f1", -1, 0, 13, 1'b0);
    frame("stall", 1, 0, 18, 1'b0);
    frame("ovr", -1, 5, 13, 1'b1);
    step();
    check("ovr_sticky", 32'(overrun), 1);

    adc_finished = 1'b0;
    out_ready = 1'b1;
    step();
    adc_finished = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid && row_sel == 1'b1 && col_sel == 1'b0) break;
    end
    out_ready = 1'b0;
    step();
    check("mid_valid", 32'(out_valid), 1);
    check("mid_data", 32'(out_data), 32'h30);
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 0);

    frame("post", -1, 0, 13, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
